rob_commit_ctrl: RTL

In-order retirement controller that sits between the reorder buffer head and the architectural state. Each cycle it inspects the ROB head entry and decides whether it retires. A retiring entry writes the register file, commits a store through a request/ack handshake, or flushes the pipeline on a branch mispredict. It drives the ROB's `dequeue_i` and the `flush` field placed on the CDB, and keeps a retired-instruction counter for RVFI ordering.

---
 rtl/rob_commit_ctrl_pkg.sv | 22 ++
 rtl/rob_commit_ctrl_if.sv | 48 ++++
 rtl/rob_commit_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/rob_commit_ctrl_pkg.sv
// Shared types for the in-order retirement controller: head commit kinds and FSM states.
package rob_commit_ctrl_pkg;

  typedef enum logic [1:0] {
    CK_REG    = 2'd0,
    CK_STORE  = 2'd1,
    CK_BRANCH = 2'd2
  } commit_kind_t;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_ST_WAIT = 2'd1,
    S_FLUSH   = 2'd2
  } state_t;

  localparam int FLUSH_W = 4;

  function automatic logic is_mispredict(input logic br_en, input logic pred);
    return br_en != pred;
  endfunction

endpackage

// File: rtl/rob_commit_ctrl_if.sv
// ROB-head / retirement bundle between the reorder buffer, register file, store path and CDB.
interface rob_commit_ctrl_if
  import rob_commit_ctrl_pkg::*;
#(
  parameter int CNT_W = 64
);
  logic               head_valid_i;
  logic               head_done_i;
  commit_kind_t       head_kind_i;
  logic               head_regf_we_i;
  logic [4:0]         head_rd_addr_i;
  logic [31:0]        head_rd_data_i;
  logic [3:0]         head_rob_idx_i;
  logic               head_br_en_i;
  logic               head_pred_i;
  logic [31:0]        head_pc_new_i;
  logic               commit_en_i;
  logic               st_ack_i;

  logic               dequeue_o;
  logic               regf_we_o;
  logic [4:0]         regf_rd_o;
  logic [31:0]        regf_data_o;
  logic [3:0]         regf_rob_idx_o;
  logic               st_req_o;
  logic [3:0]         st_rob_idx_o;
  logic               flush_o;
  logic [31:0]        redirect_pc_o;
  logic [CNT_W-1:0]   retired_cnt_o;
  logic               busy_o;

  modport slave (
    input  head_valid_i, head_done_i, head_kind_i, head_regf_we_i, head_rd_addr_i,
           head_rd_data_i, head_rob_idx_i, head_br_en_i, head_pred_i, head_pc_new_i,
           commit_en_i, st_ack_i,
    output dequeue_o, regf_we_o, regf_rd_o, regf_data_o, regf_rob_idx_o, st_req_o,
           st_rob_idx_o, flush_o, redirect_pc_o, retired_cnt_o, busy_o
  );

  modport master (
    output head_valid_i, head_done_i, head_kind_i, head_regf_we_i, head_rd_addr_i,
           head_rd_data_i, head_rob_idx_i, head_br_en_i, head_pred_i, head_pc_new_i,
           commit_en_i, st_ack_i,
    input  dequeue_o, regf_we_o, regf_rd_o, regf_data_o, regf_rob_idx_o, st_req_o,
           st_rob_idx_o, flush_o, redirect_pc_o, retired_cnt_o, busy_o
  );

endinterface

// File: rtl/rob_commit_ctrl.sv
// In-order retirement of the ROB head: register writes, store handshake, mispredict flush.
// CNT_W must match the CNT_W of the connected rob_commit_ctrl_if.
//
// state     | meaning
// S_RUN     | inspect head each cycle, retire when ready
// S_ST_WAIT | store request outstanding, waiting for st_ack_i
// S_FLUSH   | post-mispredict recovery, counting down flush_cnt_q
module rob_commit_ctrl
  import rob_commit_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 64
) (
  input  logic               clk,
  input  logic               rst,
  rob_commit_ctrl_if.slave   bus
);

  localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_CYCLES - 1);

  state_t               state_q, state_d;
  logic [FLUSH_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]     retired_q;
  logic [3:0]           st_idx_q, st_idx_d;

  logic        ready;
  logic        deq, rwe, streq, flush, busy;
  logic [4:0]  rrd;
  logic [31:0] rdata, redir;
  logic [3:0]  ridx, stidx;

  assign ready = bus.head_valid_i & bus.head_done_i & bus.commit_en_i;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    st_idx_d    = st_idx_q;
    deq         = 1'b0;
    rwe         = 1'b0;
    rrd         = '0;
    rdata       = '0;
    ridx        = '0;
    streq       = 1'b0;
    stidx       = '0;
    flush       = 1'b0;
    redir       = '0;
    busy        = 1'b0;
    // Outputs are forced quiet while reset is held, whatever the registered state.
    if (!rst) begin
      busy = (state_q != S_RUN);
      unique case (state_q)
        S_RUN: begin
          if (ready) begin
            if (bus.head_kind_i == CK_STORE) begin
              streq = 1'b1;
              stidx = bus.head_rob_idx_i;
              if (bus.st_ack_i) begin
                deq = 1'b1;
              end else begin
                st_idx_d = bus.head_rob_idx_i;
                state_d  = S_ST_WAIT;
              end
            end else if (bus.head_kind_i == CK_REG || bus.head_kind_i == CK_BRANCH) begin
              rwe = bus.head_regf_we_i & (bus.head_rd_addr_i != 5'd0);
              if (rwe) begin
                rrd   = bus.head_rd_addr_i;
                rdata = bus.head_rd_data_i;
                ridx  = bus.head_rob_idx_i;
              end
              // ROB advances its own head on flush, so a mispredict never dequeues.
              if (bus.head_kind_i == CK_BRANCH &&
                  is_mispredict(bus.head_br_en_i, bus.head_pred_i)) begin
                flush       = 1'b1;
                redir       = bus.head_pc_new_i;
                flush_cnt_d = FLUSH_LOAD;
                state_d     = S_FLUSH;
              end else begin
                deq = 1'b1;
              end
            end
          end
        end
        S_ST_WAIT: begin
          streq = 1'b1;
          stidx = st_idx_q;
          if (bus.st_ack_i) begin
            deq     = 1'b1;
            state_d = S_RUN;
          end
        end
        S_FLUSH: begin
          if (flush_cnt_q == '0) state_d = S_RUN;
          else                   flush_cnt_d = flush_cnt_q - 1'b1;
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      flush_cnt_q <= '0;
      retired_q   <= '0;
      st_idx_q    <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      st_idx_q    <= st_idx_d;
      if (deq | flush) retired_q <= retired_q + 1'b1;
    end
  end

  assign bus.dequeue_o      = deq;
  assign bus.regf_we_o      = rwe;
  assign bus.regf_rd_o      = rrd;
  assign bus.regf_data_o    = rdata;
  assign bus.regf_rob_idx_o = ridx;
  assign bus.st_req_o       = streq;
  assign bus.st_rob_idx_o   = stidx;
  assign bus.flush_o        = flush;
  assign bus.redirect_pc_o  = redir;
  assign bus.retired_cnt_o  = retired_q;
  assign bus.busy_o         = busy;

endmodule
